// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg
//   Shared definitions for the Hack data-memory map: the address-region
//   enum, default region bases/sizes, clog2-derived default widths and the
//   address decoder used by hack_mem_map.
package hack_mem_pkg;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_SCR  = 2'd1,
        REG_KBD  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    localparam int unsigned DEF_DATA_W        = 16;
    localparam int unsigned DEF_ADDR_W        = 15;
    localparam int unsigned DEF_RAM_WORDS     = 16384;
    localparam int unsigned DEF_SCREEN_BASE   = 16384;
    localparam int unsigned DEF_SCREEN_WORDS  = 8192;
    localparam int unsigned DEF_KBD_ADDR      = 24576;
    localparam int unsigned DEF_KBD_W         = 8;
    localparam int unsigned DEF_FIFO_DEPTH    = 4;
    localparam int unsigned DEF_SCREEN_SHADOW = 1;

    localparam int unsigned DEF_SCR_AW = $clog2(DEF_SCREEN_WORDS);
    localparam int unsigned DEF_LVL_W  = $clog2(DEF_FIFO_DEPTH) + 1;

    // Address decoder; the address is passed zero-extended to 32 bits so
    // the comparisons against the integer region bounds are width-clean.
    function automatic region_e decode_region(
        input logic [31:0] addr,
        input int unsigned ram_words,
        input int unsigned scr_base,
        input int unsigned scr_words,
        input int unsigned kbd_addr
    );
        if (addr < ram_words)
            return REG_RAM;
        else if ((addr >= scr_base) && (addr < (scr_base + scr_words)))
            return REG_SCR;
        else if (addr == kbd_addr)
            return REG_KBD;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/hack_wr_fifo.sv
// hack_wr_fifo
//   Synchronous write-buffer FIFO with a valid/ready output side.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     i_push          push request (ignored while o_full)
//     i_push_data     pushed word
//     o_full          level == DEPTH
//     o_valid         head word present (registered: level != 0)
//     i_ready         consumer accepts head
//     o_data          head word
//     o_level         occupancy, 0..DEPTH
//
//   Handshake: a word transfers on every clock edge where o_valid and
//   i_ready are both high; while o_valid is high and i_ready is low the
//   head word and o_valid hold steady.
module hack_wr_fifo
    import hack_mem_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_data,
    output logic [LVL_W-1:0] o_level
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("hack_wr_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_valid;

    logic             w_push;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_nxt;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign w_push  = i_push & ~o_full;
    assign w_pop   = r_valid & i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)
            w_level_nxt = r_level + LVL_W'(1);
        else if (!w_push && w_pop)
            w_level_nxt = r_level - LVL_W'(1);
    end

    // Storage is not reset; only pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
        end
    end

endmodule

// File: rtl/hack_mem_map.sv
// hack_mem_map
//   Hack data-memory map: routes the CPU data port to general RAM, the
//   screen write FIFO (plus optional shadow RAM) and the keyboard register.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     cpu_addr       CPU data address
//     cpu_wdata      CPU write data
//     cpu_load       write strobe (0 = read)
//     cpu_stall      screen write refused this cycle (FIFO full)
//     cpu_rdata      registered read data, 1 cycle after the address
//     kbd_in         raw keyboard code, asynchronous to clk
//     scr_addr       screen word offset of the FIFO head
//     scr_data       pixel word of the FIFO head
//     scr_valid      FIFO head valid
//     scr_ready      screen controller accepts head
//     fifo_level     screen FIFO occupancy
//     unmapped_err   one-cycle pulse: unmapped access or write to keyboard
module hack_mem_map
    import hack_mem_pkg::*;
#(
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned RAM_WORDS     = DEF_RAM_WORDS,
    parameter int unsigned SCREEN_BASE   = DEF_SCREEN_BASE,
    parameter int unsigned SCREEN_WORDS  = DEF_SCREEN_WORDS,
    parameter int unsigned KBD_ADDR      = DEF_KBD_ADDR,
    parameter int unsigned KBD_W         = DEF_KBD_W,
    parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int unsigned SCREEN_SHADOW = DEF_SCREEN_SHADOW,
    localparam int unsigned SCR_AW = $clog2(SCREEN_WORDS),
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned RAM_AW = $clog2(RAM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_load,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [KBD_W-1:0]  kbd_in,
    output logic [SCR_AW-1:0] scr_addr,
    output logic [DATA_W-1:0] scr_data,
    output logic              scr_valid,
    input  logic              scr_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              unmapped_err
);

    if ((RAM_WORDS > SCREEN_BASE) ||
        (KBD_ADDR < RAM_WORDS) ||
        ((KBD_ADDR >= SCREEN_BASE) && (KBD_ADDR < SCREEN_BASE + SCREEN_WORDS)))
    begin : g_overlap
        $error("hack_mem_map: RAM, screen and keyboard regions overlap");
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [31:0]       w_addr_ext;
    region_e           w_region;
    logic [SCR_AW-1:0] w_scr_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_fifo_full;
    logic              w_scr_push;
    logic              w_ram_we;
    logic              w_err;
    logic [DATA_W-1:0] w_shadow_rd;

    assign w_addr_ext = 32'(cpu_addr);
    assign w_region   = decode_region(w_addr_ext, RAM_WORDS, SCREEN_BASE,
                                      SCREEN_WORDS, KBD_ADDR);
    assign w_scr_off  = SCR_AW'(w_addr_ext - SCREEN_BASE);
    assign w_ram_idx  = cpu_addr[RAM_AW-1:0];

    // Stall looks only at the current level: a pop on the same edge does
    // not let the write in, it is taken on the following cycle.
    assign cpu_stall  = cpu_load & (w_region == REG_SCR) & w_fifo_full;
    assign w_scr_push = cpu_load & (w_region == REG_SCR) & ~w_fifo_full;
    assign w_ram_we   = cpu_load & (w_region == REG_RAM);
    assign w_err      = (w_region == REG_NONE) |
                        (cpu_load & (w_region == REG_KBD));

    // ------------------------------------------------------------------
    // General RAM (not reset). The read below samples the array after the
    // previous edge's write, so read-after-write returns the new word.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[w_ram_idx] <= cpu_wdata;
    end

    // ------------------------------------------------------------------
    // Screen shadow RAM
    // ------------------------------------------------------------------
    if (SCREEN_SHADOW != 0) begin : g_shadow
        logic [DATA_W-1:0] r_shadow [SCREEN_WORDS];

        always_ff @(posedge clk) begin
            if (w_scr_push)
                r_shadow[w_scr_off] <= cpu_wdata;
        end

        assign w_shadow_rd = r_shadow[w_scr_off];
    end else begin : g_no_shadow
        assign w_shadow_rd = '0;
    end

    // ------------------------------------------------------------------
    // Keyboard: two-flop synchroniser followed by a holding register
    // ------------------------------------------------------------------
    logic [KBD_W-1:0] r_kbd_s1;
    logic [KBD_W-1:0] r_kbd_s2;
    logic [KBD_W-1:0] r_kbd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kbd_s1 <= '0;
            r_kbd_s2 <= '0;
            r_kbd    <= '0;
        end else begin
            r_kbd_s1 <= kbd_in;
            r_kbd_s2 <= r_kbd_s1;
            r_kbd    <= r_kbd_s2;
        end
    end

    // ------------------------------------------------------------------
    // Read data and error pulse
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            // Write cycles leave the read data untouched.
            if (!cpu_load) begin
                case (w_region)
                    REG_RAM: r_rdata <= r_ram[w_ram_idx];
                    REG_SCR: r_rdata <= w_shadow_rd;
                    REG_KBD: r_rdata <= DATA_W'(r_kbd);
                    default: r_rdata <= '0;
                endcase
            end
        end
    end

    assign cpu_rdata    = r_rdata;
    assign unmapped_err = r_err;

    // ------------------------------------------------------------------
    // Screen write FIFO: entries are {offset, pixel word}
    // ------------------------------------------------------------------
    logic [SCR_AW+DATA_W-1:0] w_fifo_head;

    hack_wr_fifo #(
        .W     (SCR_AW + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_scr_push),
        .i_push_data ({w_scr_off, cpu_wdata}),
        .o_full      (w_fifo_full),
        .o_valid     (scr_valid),
        .i_ready     (scr_ready),
        .o_data      (w_fifo_head),
        .o_level     (fifo_level)
    );

    assign scr_addr = w_fifo_head[SCR_AW+DATA_W-1:DATA_W];
    assign scr_data = w_fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_hack_mem_map.sv
// tb_hack_mem_map
//   Directed bench for hack_mem_map with default parameters.
module tb_hack_mem_map;
    import hack_mem_pkg::*;

    localparam int unsigned SB  = 16384;
    localparam int unsigned KBD = 24576;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [14:0]           cpu_addr;
    logic [15:0]           cpu_wdata;
    logic                  cpu_load;
    logic                  cpu_stall;
    logic [15:0]           cpu_rdata;
    logic [7:0]            kbd_in;
    logic [DEF_SCR_AW-1:0] scr_addr;
    logic [15:0]           scr_data;
    logic                  scr_valid;
    logic                  scr_ready;
    logic [DEF_LVL_W-1:0]  fifo_level;
    logic                  unmapped_err;

    int n_checks = 0;
    int n_errors = 0;

    hack_mem_map dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_load     (cpu_load),
        .cpu_stall    (cpu_stall),
        .cpu_rdata    (cpu_rdata),
        .kbd_in       (kbd_in),
        .scr_addr     (scr_addr),
        .scr_data     (scr_data),
        .scr_valid    (scr_valid),
        .scr_ready    (scr_ready),
        .fifo_level   (fifo_level),
        .unmapped_err (unmapped_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input int unsigned addr, input logic [15:0] data, input logic load);
        cpu_addr  = 15'(addr);
        cpu_wdata = data;
        cpu_load  = load;
    endtask

    initial begin
        rst_n     = 1'b0;
        kbd_in    = 8'h00;
        scr_ready = 1'b0;
        set_bus(0, 16'h0000, 1'b0);

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_rdata_0", 32'(cpu_rdata), 32'h0);
        check("rst_valid", 32'(scr_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_err", 32'(unmapped_err), 32'h0);
        set_bus(SB, 16'h0000, 1'b0);
        tick();
        check("rst_rdata_scr", 32'(cpu_rdata), 32'h0);
        set_bus(KBD, 16'h0000, 1'b0);
        tick();
        check("rst_rdata_kbd", 32'(cpu_rdata), 32'h0);
        rst_n = 1'b1;
        tick();
        check("kbd_read_after_rst", 32'(cpu_rdata), 32'h0);
        check("err_after_rst", 32'(unmapped_err), 32'h0);

        // ---------------- RAM write / read ----------------
        set_bus(100, 16'h1234, 1'b1);
        tick();
        check("ram_wr_hold", 32'(cpu_rdata), 32'h0);
        set_bus(100, 16'h0000, 1'b0);
        tick();
        check("ram_raw_100", 32'(cpu_rdata), 32'h1234);
        check("ram_no_valid", 32'(scr_valid), 32'h0);
        set_bus(101, 16'h5678, 1'b1);
        tick();
        check("ram_wr_hold2", 32'(cpu_rdata), 32'h1234);
        set_bus(101, 16'h0000, 1'b0);
        tick();
        check("ram_raw_101", 32'(cpu_rdata), 32'h5678);

        // ---------------- FIFO fill and stall ----------------
        scr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_bus(SB + i, 16'hA000 + 16'(i), 1'b1);
            tick();
        end
        check("fill_level", 32'(fifo_level), 32'd4);
        check("fill_valid", 32'(scr_valid), 32'h1);
        set_bus(SB + 4, 16'hA004, 1'b1);
        #1;
        check("stall_full", 32'(cpu_stall), 32'h1);
        tick();
        check("stall_level", 32'(fifo_level), 32'd4);
        check("stall_held", 32'(cpu_stall), 32'h1);
        check("head0_data", 32'(scr_data), 32'hA000);
        check("head0_addr", 32'(scr_addr), 32'd0);
        scr_ready = 1'b1;
        #1;
        check("stall_ignores_pop", 32'(cpu_stall), 32'h1);
        tick();
        check("drain1_level", 32'(fifo_level), 32'd3);
        check("drain1_stall", 32'(cpu_stall), 32'h0);
        check("head1_data", 32'(scr_data), 32'hA001);
        check("head1_addr", 32'(scr_addr), 32'd1);
        tick();
        check("pushpop_level", 32'(fifo_level), 32'd3);
        check("head2_data", 32'(scr_data), 32'hA002);
        check("head2_addr", 32'(scr_addr), 32'd2);
        set_bus(100, 16'h0000, 1'b0);
        tick();
        check("head3_data", 32'(scr_data), 32'hA003);
        check("head3_addr", 32'(scr_addr), 32'd3);
        tick();
        check("head4_data", 32'(scr_data), 32'hA004);
        check("head4_addr", 32'(scr_addr), 32'd4);
        check("head4_level", 32'(fifo_level), 32'd1);
        tick();
        check("drained_valid", 32'(scr_valid), 32'h0);
        check("drained_level", 32'(fifo_level), 32'd0);

        // ---------------- simultaneous push/pop at level 2 ----------------
        scr_ready = 1'b0;
        set_bus(SB, 16'hB000, 1'b1);
        tick();
        set_bus(SB + 1, 16'hB001, 1'b1);
        tick();
        check("pp_level2", 32'(fifo_level), 32'd2);
        set_bus(SB + 2, 16'hB002, 1'b1);
        scr_ready = 1'b1;
        tick();
        check("pp_level_same", 32'(fifo_level), 32'd2);
        check("pp_head_b001", 32'(scr_data), 32'hB001);
        set_bus(SB + 1, 16'h0000, 1'b0);
        tick();
        check("pp_head_b002", 32'(scr_data), 32'hB002);
        check("pp_head_off2", 32'(scr_addr), 32'd2);
        check("shadow_16385", 32'(cpu_rdata), 32'hB001);
        set_bus(SB, 16'h0000, 1'b0);
        tick();
        check("pp_empty", 32'(fifo_level), 32'd0);
        check("shadow_16384", 32'(cpu_rdata), 32'hB000);
        scr_ready = 1'b0;

        // ---------------- keyboard ----------------
        set_bus(KBD, 16'h0000, 1'b0);
        kbd_in = 8'h41;
        tick();
        check("kbd_lat1", 32'(cpu_rdata), 32'h0);
        tick();
        check("kbd_lat2", 32'(cpu_rdata), 32'h0);
        tick();
        tick();
        tick();
        check("kbd_value", 32'(cpu_rdata), 32'h0041);
        check("kbd_read_no_err", 32'(unmapped_err), 32'h0);
        set_bus(KBD, 16'hFFFF, 1'b1);
        tick();
        check("kbd_wr_err", 32'(unmapped_err), 32'h1);
        check("kbd_wr_hold", 32'(cpu_rdata), 32'h0041);
        set_bus(KBD, 16'h0000, 1'b0);
        tick();
        check("kbd_err_pulse_end", 32'(unmapped_err), 32'h0);
        check("kbd_unchanged", 32'(cpu_rdata), 32'h0041);

        // ---------------- unmapped ----------------
        set_bus(16'h7000, 16'h0000, 1'b0);
        tick();
        check("unm_rdata", 32'(cpu_rdata), 32'h0);
        check("unm_err", 32'(unmapped_err), 32'h1);
        set_bus(100, 16'h0000, 1'b0);
        tick();
        check("unm_err_end", 32'(unmapped_err), 32'h0);
        check("ram_after_unm", 32'(cpu_rdata), 32'h1234);
        set_bus(16'h7FFF, 16'hDEAD, 1'b1);
        tick();
        check("unm_wr_err", 32'(unmapped_err), 32'h1);
        check("unm_wr_no_stall", 32'(cpu_stall), 32'h0);

        // ---------------- reset mid-burst ----------------
        scr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_bus(SB + 8 + i, 16'hC000 + 16'(i), 1'b1);
            tick();
        end
        check("burst_level3", 32'(fifo_level), 32'd3);
        check("burst_valid", 32'(scr_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(scr_valid), 32'h0);
        check("async_rst_level", 32'(fifo_level), 32'd0);
        check("async_rst_rdata", 32'(cpu_rdata), 32'h0);
        set_bus(100, 16'h0000, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_level", 32'(fifo_level), 32'd0);
        check("post_rst_ram", 32'(cpu_rdata), 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
